// File: rtl/mem_arbiter.sv
// Shares one RAM between instruction fetch and load/store. Data has priority;
// a saturating wait counter forces fetch ahead after MAX_WAIT data grants.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_done,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          we_q, we_d;
  logic          f_ack_q, f_ack_d, d_ack_q, d_ack_d;
  logic          ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic          owner_q, owner_d, busy_q, busy_d;
  logic          pick_data;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    owner_d     = owner_q;
    pick_data   = d_req && (!f_req || (wait_cnt_q != MAX_CNT));

    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          state_d  = ISSUE;
          ram_en_d = 1'b1;
          owner_d  = pick_data;
          if (pick_data) begin
            ram_addr_d  = d_addr;
            ram_wdata_d = d_wdata;
            we_d        = d_we;
            ram_we_d    = d_we;
            // only count data wins that actually made fetch wait
            if (f_req && (wait_cnt_q != MAX_CNT))
              wait_cnt_d = wait_cnt_q + CW'(1);
          end else begin
            ram_addr_d = f_addr;
            we_d       = 1'b0;
            wait_cnt_d = '0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ram_done) begin
          state_d = DONE;
          f_ack_d = !owner_q;
          d_ack_d = owner_q;
          if (!owner_q)   f_rdata_d = ram_rdata;
          else if (!we_q) d_rdata_d = ram_rdata;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      we_q        <= 1'b0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single program/data RAM between the instruction-fetch path (control unit / instruction register) and the load/store data path. Two requesters issue held-request transactions; the arbiter picks one, drives the RAM with a one-cycle enable pulse, waits for the RAM done strobe, returns read data, and pulses an acknowledge to the winner. Data accesses have priority over fetch, and a starvation counter guarantees that fetch progresses.

## Interface
Parameters:
- AW, 8, RAM address width
- DW, 16, RAM data width
- MAX_WAIT, 4, consecutive data grants, taken while fetch is waiting, before fetch is forced ahead; must be ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  AW  fetch address
- f_ack  out  1  one-cycle fetch completion pulse
- f_rdata  out  DW  fetch read data; valid with f_ack, held afterwards
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  data read data; valid with d_ack, held afterwards
- ram_en  out  1  one-cycle RAM start pulse
- ram_we  out  1  RAM write enable; qualifies ram_en
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data; valid with ram_done
- ram_done  in  1  RAM completion strobe
- busy  out  1  high in any state except IDLE
- owner  out  1  current or last grantee: 0 = fetch, 1 = data

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- Reset values: state IDLE, all acks 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0, f_rdata 0, d_rdata 0, owner 0, busy 0, wait_cnt 0.
- IDLE: if any request is high, choose a winner, latch its address, write data and we, then go to ISSUE. If no request is high, stay in IDLE.
- Arbitration when only one request is high: that requester wins.
- Arbitration when both are high: data wins unless wait_cnt == MAX_WAIT, in which case fetch wins.
- wait_cnt:
  - increments, saturating at MAX_WAIT, on each data grant made while f_req is high
  - clears on every fetch grant
  - otherwise unchanged
  - width is $clog2(MAX_WAIT+1)
- ISSUE: ram_en = 1 for exactly this cycle; ram_we = latched d_we for a data grant, 0 for a fetch grant. Next state is WAIT.
- WAIT: ram_addr and ram_wdata stay stable. On ram_done:
  - capture ram_rdata into the winner's rdata register (reads only; a data write leaves d_rdata unchanged)
  - go to DONE
- DONE: the winner's ack = 1 for exactly this cycle. Next state is IDLE.
- ram_done is ignored in IDLE, ISSUE and DONE.
- A request dropped after the grant does not abort the transaction; the ack still pulses. Requester inputs are ignored outside IDLE.
- Reset mid-transaction: immediately return to the reset values. The transaction is discarded and no ack is produced.

## Timing
- A grant is decided at the edge that samples the request in IDLE. ram_en is high in the following cycle.
- Minimum transaction, from the grant edge to the end of the ack: 4 cycles (ISSUE, WAIT with ram_done already high, DONE, back to IDLE). Each extra RAM latency cycle adds one WAIT cycle.
- The ack is high for one cycle. The requester drops its request at the edge ending that ack cycle. IDLE samples again one cycle later, so no duplicate grant can occur.
- Back-to-back throughput is one transaction per 4 + (RAM latency − 1) cycles.

## Test plan
- Single fetch: f_req=1, f_addr=0x10; RAM returns 0xABCD with ram_done one cycle after ram_en.
  - Expect ram_en=1 and ram_we=0 for one cycle with ram_addr=0x10.
  - Expect f_ack pulse with f_rdata=0xABCD, owner=0, and busy low again the cycle after the ack.
- Data write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x1234.
  - Expect ram_en and ram_we high together with ram_addr=0x20 and ram_wdata=0x1234.
  - Expect a d_ack pulse, with d_rdata unchanged.
- Simultaneous requests with MAX_WAIT=4: f_req and d_req both held high, data re-requesting immediately after each d_ack.
  - Expect 4 data grants, then a fetch grant, and wait_cnt=0 after the fetch grant.
- Slow RAM: ram_done held low for 5 cycles.
  - Expect ram_en high for a single cycle.
  - Expect ram_addr stable throughout, the ack exactly one cycle after ram_done, and no ack before it.
- Stray strobe, then reset mid-operation:
  - A ram_done pulse in IDLE causes no ack.
  - Asserting rst=0 during WAIT drives all outputs to reset values asynchronously; after release no ack appears for the aborted transaction.
